// File: rtl/axi_slave_mem_responder.sv
// Memory-backed AXI4 slave endpoint: one write and one read burst in flight,
// FIXED/INCR/WRAP addressing, byte strobes and programmable AxREADY latency.
module axi_slave_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int ID_WIDTH    = 4,
    parameter int MEM_DEPTH   = 256,
    parameter int BASE_ADDR   = 0,
    parameter int READY_DELAY = 0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     S_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
    input  logic [7:0]              S_AWLEN,
    input  logic [1:0]              S_AWBURST,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic                    S_WLAST,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic [ID_WIDTH-1:0]     S_BID,
    output logic [1:0]              S_BRESP,
    output logic                    S_BVALID,
    input  logic                    S_BREADY,
    input  logic [ID_WIDTH-1:0]     S_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
    input  logic [7:0]              S_ARLEN,
    input  logic [1:0]              S_ARBURST,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    output logic [ID_WIDTH-1:0]     S_RID,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic                    S_RLAST,
    output logic                    S_RVALID,
    input  logic                    S_RREADY
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int SH = $clog2(SW);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] BYTES_A = ADDR_WIDTH'(SW);
    localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [4:0] DLY = 5'(READY_DELAY);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] B_WRAP  = 2'b10;
    localparam logic [1:0] RSP_OK  = 2'b00;
    localparam logic [1:0] RSP_SLV = 2'b10;
    localparam logic [1:0] RSP_DEC = 2'b11;

    function automatic logic wrap_ok(input logic [7:0] len);
        return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    endfunction

    function automatic logic burst_err(input logic [1:0] b, input logic [7:0] len);
        return (b == 2'b11) || (b == B_WRAP && !wrap_ok(len));
    endfunction

    // Illegal bursts are folded into INCR here so the advance logic never sees them.
    function automatic logic [1:0] eff_burst(input logic [1:0] b, input logic [7:0] len);
        if (b == B_FIXED) return B_FIXED;
        if (b == B_WRAP && wrap_ok(len)) return B_WRAP;
        return B_INCR;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [1:0]            b
    );
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] win;
        inc = a + BYTES_A;
        win = ((ADDR_WIDTH'(len) + 1'b1) << SH) - 1'b1;
        case (b)
            B_FIXED: return a;
            B_WRAP:  return (a & ~win) | (inc & win);
            default: return inc;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Write path state
    logic [1:0]            wstate_q, wstate_d;
    logic [4:0]            awcnt_q, awcnt_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [1:0]            wburst_q, wburst_d;
    logic [7:0]            wbeat_q, wbeat_d;
    logic                  wdec_q, wdec_d;
    logic                  wslv_q, wslv_d;

    logic                  aw_hs, w_hs, b_hs, w_ok, w_last_exp, mem_we;
    logic [ADDR_WIDTH-1:0] w_off, w_idx;

    assign aw_hs      = S_AWVALID && awready_q;
    assign w_hs       = S_WVALID && wready_q;
    assign b_hs       = bvalid_q && S_BREADY;
    assign w_off      = waddr_q - BASE_A;
    assign w_idx      = w_off >> SH;
    assign w_ok       = (waddr_q >= BASE_A) && (w_idx < DEPTH_A);
    assign w_last_exp = (wbeat_q == wlen_q);
    assign mem_we     = w_hs && w_ok;

    always_comb begin
        wstate_d  = wstate_q;
        awcnt_d   = awcnt_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wburst_d  = wburst_q;
        wbeat_d   = wbeat_q;
        wdec_d    = wdec_q;
        wslv_d    = wslv_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    bid_d     = S_AWID;
                    waddr_d   = S_AWADDR;
                    wlen_d    = S_AWLEN;
                    wburst_d  = eff_burst(S_AWBURST, S_AWLEN);
                    wslv_d    = burst_err(S_AWBURST, S_AWLEN);
                    wdec_d    = 1'b0;
                    wbeat_d   = 8'd0;
                    awcnt_d   = 5'd0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wstate_d  = W_DATA;
                end else begin
                    if (!S_AWVALID) awcnt_d = 5'd0;
                    else if (awcnt_q < DLY) awcnt_d = awcnt_q + 5'd1;
                    awready_d = (awcnt_d >= DLY);
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
                    wbeat_d = wbeat_q + 8'd1;
                    if (!w_ok) wdec_d = 1'b1;
                    if (S_WLAST != w_last_exp) wslv_d = 1'b1;
                    // A stray or missing WLAST still closes the burst on this beat.
                    if (S_WLAST || w_last_exp) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        wstate_d = W_RESP;
                        if (!w_ok || wdec_q) bresp_d = RSP_DEC;
                        else if (wslv_q || S_WLAST != w_last_exp) bresp_d = RSP_SLV;
                        else bresp_d = RSP_OK;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    bvalid_d  = 1'b0;
                    awcnt_d   = 5'd0;
                    awready_d = (DLY == 5'd0);
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q  <= W_IDLE;
            awcnt_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            wbeat_q   <= '0;
            wdec_q    <= 1'b0;
            wslv_q    <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            awcnt_q   <= awcnt_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            wdec_q    <= wdec_d;
            wslv_q    <= wslv_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < SW; b++) begin
                if (S_WSTRB[b]) mem_q[w_idx[IW-1:0]][8*b +: 8] <= S_WDATA[8*b +: 8];
            end
        end
    end

    // Read path state
    logic                  rstate_q, rstate_d;
    logic [4:0]            arcnt_q, arcnt_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [1:0]            rburst_q, rburst_d;
    logic [7:0]            rbeat_q, rbeat_d;
    logic                  rslv_q, rslv_d;

    logic                  ar_hs, r_hs, r_ok;
    logic [ADDR_WIDTH-1:0] r_src, r_off, r_idx;
    logic [DATA_WIDTH-1:0] r_word;

    // In idle the first beat is fetched straight from the AR channel.
    assign r_src  = (rstate_q == R_IDLE) ? S_ARADDR : raddr_q;
    assign r_off  = r_src - BASE_A;
    assign r_idx  = r_off >> SH;
    assign r_ok   = (r_src >= BASE_A) && (r_idx < DEPTH_A);
    assign r_word = r_ok ? mem_q[r_idx[IW-1:0]] : '0;
    assign ar_hs  = S_ARVALID && arready_q;
    assign r_hs   = rvalid_q && S_RREADY;

    always_comb begin
        rstate_d  = rstate_q;
        arcnt_d   = arcnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rbeat_d   = rbeat_q;
        rslv_d    = rslv_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rid_d     = S_ARID;
                    rlen_d    = S_ARLEN;
                    rburst_d  = eff_burst(S_ARBURST, S_ARLEN);
                    rslv_d    = burst_err(S_ARBURST, S_ARLEN);
                    raddr_d   = next_addr(S_ARADDR, S_ARLEN, rburst_d);
                    rbeat_d   = 8'd0;
                    rdata_d   = r_word;
                    rresp_d   = !r_ok ? RSP_DEC : (rslv_d ? RSP_SLV : RSP_OK);
                    rlast_d   = (S_ARLEN == 8'd0);
                    rvalid_d  = 1'b1;
                    arcnt_d   = 5'd0;
                    arready_d = 1'b0;
                    rstate_d  = R_DATA;
                end else begin
                    if (!S_ARVALID) arcnt_d = 5'd0;
                    else if (arcnt_q < DLY) arcnt_d = arcnt_q + 5'd1;
                    arready_d = (arcnt_d >= DLY);
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arcnt_d   = 5'd0;
                        arready_d = (DLY == 5'd0);
                        rstate_d  = R_IDLE;
                    end else begin
                        rdata_d = r_word;
                        rresp_d = !r_ok ? RSP_DEC : (rslv_q ? RSP_SLV : RSP_OK);
                        rlast_d = (rbeat_q + 8'd1 == rlen_q);
                        rbeat_d = rbeat_q + 8'd1;
                        raddr_d = next_addr(raddr_q, rlen_q, rburst_q);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_q  <= R_IDLE;
            arcnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            rbeat_q   <= '0;
            rslv_q    <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            arcnt_q   <= arcnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
            rslv_q    <= rslv_d;
        end
    end

    assign S_AWREADY = awready_q;
    assign S_WREADY  = wready_q;
    assign S_BVALID  = bvalid_q;
    assign S_BID     = bid_q;
    assign S_BRESP   = bresp_q;
    assign S_ARREADY = arready_q;
    assign S_RVALID  = rvalid_q;
    assign S_RLAST   = rlast_q;
    assign S_RID     = rid_q;
    assign S_RDATA   = rdata_q;
    assign S_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Bench for axi_slave_mem_responder: directed vector table, reset corners
// and randomized bursts checked against a byte-level memory model.
module tb_axi_slave_mem_responder;

    localparam int          DLY   = 3;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h100;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S_AWID, S_ARID, S_BID, S_RID;
    logic [31:0] S_AWADDR, S_ARADDR;
    logic [7:0]  S_AWLEN, S_ARLEN, S_WSTRB;
    logic [1:0]  S_AWBURST, S_ARBURST, S_BRESP, S_RRESP;
    logic        S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY;
    logic        S_BVALID, S_BREADY, S_ARVALID, S_ARREADY;
    logic        S_RLAST, S_RVALID, S_RREADY;
    logic [63:0] S_WDATA, S_RDATA;

    axi_slave_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4),
        .MEM_DEPTH(DEPTH), .BASE_ADDR(32'h100), .READY_DELAY(DLY)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN),
        .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
        .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] ref_mem [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          wl;
        logic [7:0]  strb;
        int          bresp;
        int          rresp0;
    } vec_t;
    vec_t vt [12];

    task automatic check(input bit ok, input string nm,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return a >= BASE && (a - BASE) / 8 < DEPTH;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 8);
    endfunction

    function automatic bit berr(input logic [1:0] b, input logic [7:0] len);
        bit wok;
        wok = (len == 1 || len == 3 || len == 7 || len == 15);
        return b == 2'b11 || (b == 2'b10 && !wok);
    endfunction

    // Address of beat i computed from the burst rules directly.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [1:0] b, input int i);
        logic [31:0] sz, lo;
        sz = (32'(len) + 1) * 8;
        if (b == 2'b00) return a;
        if (b == 2'b10 && !berr(b, len)) begin
            lo = (a / sz) * sz;
            return lo + ((a - lo + 32'(i) * 8) % sz);
        end
        return a + 32'(i) * 8;
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] bur,
                            input int wl, input logic [7:0] strb,
                            input int exp, input bit rnd);
        int n, nb;
        bit dec;
        logic [31:0] a;
        logic [63:0] d;
        logic [1:0] er;
        S_AWID = id; S_AWADDR = addr; S_AWLEN = len; S_AWBURST = bur;
        S_AWVALID = 1'b1;
        n = 0;
        while (!S_AWREADY && n < 40) begin
            @(posedge ACLK); #1; n++;
        end
        check(S_AWREADY && n == DLY, "aw_delay", 64'(n), 64'(DLY));
        if (!S_AWREADY) begin
            S_AWVALID = 1'b0;
            return;
        end
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0;
        nb = (wl < int'(len)) ? wl + 1 : int'(len) + 1;
        dec = 1'b0;
        for (int i = 0; i < nb; i++) begin
            d = rnd ? {$urandom, $urandom} : 64'hA0 + 64'(i);
            S_WDATA = d; S_WSTRB = strb; S_WLAST = (i == wl); S_WVALID = 1'b1;
            check(S_WREADY === 1'b1, "wready", 64'(S_WREADY), 64'd1);
            a = beat_addr(addr, len, bur, i);
            if (in_rng(a)) begin
                for (int b = 0; b < 8; b++)
                    if (strb[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
            end else dec = 1'b1;
            @(posedge ACLK); #1;
        end
        S_WVALID = 1'b0; S_WLAST = 1'b0;
        if (exp >= 0) er = 2'(exp);
        else er = dec ? 2'b11 : (berr(bur, len) || wl != int'(len)) ? 2'b10 : 2'b00;
        check({S_BVALID, S_WREADY, S_BID, S_BRESP} === {1'b1, 1'b0, id, er}, "bresp",
              64'({S_BVALID, S_WREADY, S_BID, S_BRESP}), 64'({1'b1, 1'b0, id, er}));
        S_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] bur,
                           input int exp0, input bit tog);
        int n;
        logic [31:0] a;
        logic [63:0] ed, hold;
        logic [1:0] er;
        S_ARID = id; S_ARADDR = addr; S_ARLEN = len; S_ARBURST = bur;
        S_ARVALID = 1'b1;
        n = 0;
        while (!S_ARREADY && n < 40) begin
            @(posedge ACLK); #1; n++;
        end
        check(S_ARREADY && n == DLY, "ar_delay", 64'(n), 64'(DLY));
        if (!S_ARREADY) begin
            S_ARVALID = 1'b0;
            return;
        end
        @(posedge ACLK); #1;
        S_ARVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, bur, i);
            ed = in_rng(a) ? ref_mem[widx(a)] : 64'd0;
            er = !in_rng(a) ? 2'b11 : berr(bur, len) ? 2'b10 : 2'b00;
            if (i == 0 && exp0 >= 0) er = 2'(exp0);
            check(S_RDATA === ed, "rdata", S_RDATA, ed);
            check({S_RVALID, S_RLAST, S_RRESP, S_RID} === {1'b1, i == int'(len), er, id},
                  "rctl", 64'({S_RVALID, S_RLAST, S_RRESP, S_RID}),
                  64'({1'b1, i == int'(len), er, id}));
            if (tog) begin
                hold = S_RDATA;
                @(posedge ACLK); #1;
                check(S_RVALID === 1'b1 && S_RDATA === hold, "r_hold", S_RDATA, hold);
            end
            S_RREADY = 1'b1;
            @(posedge ACLK); #1;
            S_RREADY = 1'b0;
        end
        check(S_RVALID === 1'b0, "r_end", 64'(S_RVALID), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] ad;
        logic [7:0] ln;
        logic [1:0] bu;
        int wl;
        vt[0]  = '{32'h110, 8'd3,  2'b01, 3, 8'hFF, 0, 0};
        vt[1]  = '{32'h128, 8'd3,  2'b10, 3, 8'hFF, 0, 0};
        vt[2]  = '{32'h300, 8'd0,  2'b01, 0, 8'hFF, 3, 3};
        vt[3]  = '{32'h110, 8'd3,  2'b01, 1, 8'hFF, 2, 0};
        vt[4]  = '{32'h140, 8'd0,  2'b01, 0, 8'h0F, 0, 0};
        vt[5]  = '{32'h0F8, 8'd1,  2'b01, 1, 8'hFF, 3, 3};
        vt[6]  = '{32'h150, 8'd2,  2'b10, 2, 8'hFF, 2, 2};
        vt[7]  = '{32'h160, 8'd1,  2'b11, 1, 8'hFF, 2, 2};
        vt[8]  = '{32'h170, 8'd2,  2'b00, 2, 8'hFF, 0, 0};
        vt[9]  = '{32'h180, 8'd2,  2'b01, 5, 8'hFF, 2, 0};
        vt[10] = '{32'h2F8, 8'd1,  2'b01, 1, 8'hFF, 3, 0};
        vt[11] = '{32'h1F0, 8'd15, 2'b10, 15, 8'h3C, 0, 0};

        ARESET = 1'b1;
        S_AWID = '0; S_AWADDR = '0; S_AWLEN = '0; S_AWBURST = '0; S_AWVALID = 1'b0;
        S_WDATA = '0; S_WSTRB = '0; S_WLAST = 1'b0; S_WVALID = 1'b0; S_BREADY = 1'b0;
        S_ARID = '0; S_ARADDR = '0; S_ARLEN = '0; S_ARBURST = '0; S_ARVALID = 1'b0;
        S_RREADY = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        check({S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, S_RLAST} === 6'd0,
              "rst_ctl", 64'({S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, S_RLAST}), 0);
        check({S_BID, S_BRESP, S_RID, S_RRESP} === 12'd0 && S_RDATA === 64'd0, "rst_data",
              64'({S_BID, S_BRESP, S_RID, S_RRESP}), 0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        check({S_AWREADY, S_ARREADY} === 2'b00, "idle_ready",
              64'({S_AWREADY, S_ARREADY}), 0);

        do_write(4'h1, BASE, 8'd63, 2'b01, 63, 8'hFF, 0, 1'b1);

        foreach (vt[k]) begin
            do_write(4'(k), vt[k].addr, vt[k].len, vt[k].burst, vt[k].wl,
                     vt[k].strb, vt[k].bresp, 1'b0);
            do_read(4'(k + 3), vt[k].addr, vt[k].len, vt[k].burst,
                    vt[k].rresp0, k[0]);
        end

        fork
            do_write(4'h5, BASE, 8'd7, 2'b01, 7, 8'hFF, 0, 1'b1);
            do_read(4'h6, BASE + 32'h100, 8'd7, 2'b01, 0, 1'b0);
        join

        S_ARID = 4'h9; S_ARADDR = BASE; S_ARLEN = 8'd7; S_ARBURST = 2'b01;
        S_ARVALID = 1'b1;
        n = 0;
        while (!S_ARREADY && n < 40) begin
            @(posedge ACLK); #1; n++;
        end
        check(S_ARREADY === 1'b1, "mid_ar", 64'(S_ARREADY), 64'd1);
        @(posedge ACLK); #1;
        S_ARVALID = 1'b0;
        S_RREADY = 1'b1;
        repeat (2) begin
            @(posedge ACLK); #1;
        end
        check(S_RVALID === 1'b1, "mid_busy", 64'(S_RVALID), 64'd1);
        ARESET = 1'b1;
        #1;
        check({S_RVALID, S_ARREADY, S_RLAST} === 3'b000 && S_RDATA === 64'd0, "rst_mid",
              64'({S_RVALID, S_ARREADY, S_RLAST}), 0);
        S_RREADY = 1'b0;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        do_read(4'hA, BASE + 32'h20, 8'd3, 2'b01, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            ad = BASE - 32'h40 + 32'($urandom_range(0, DEPTH * 8 + 32'h80));
            bu = 2'($urandom_range(0, 3));
            ln = 8'($urandom_range(0, 7));
            if (bu == 2'b10 && $urandom_range(0, 1) == 1) ln = 8'(2 ** $urandom_range(1, 3) - 1);
            wl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : int'(ln);
            do_write(4'($urandom), ad, ln, bu, wl, 8'($urandom), -1, 1'b1);
            do_read(4'($urandom), ad, ln, bu, -1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem_responder.md
# axi_slave_mem_responder

Parametrised synthesizable AXI4 slave responder that replaces fixed per-slave signal bundles with a configurable memory-backed slave endpoint, attachable to any slave port (S0–S6) of the 4-master/7-slave interconnect. It accepts one write burst and one read burst at a time, fully independently. Write data is stored in an internal word-addressed memory and returned on reads. It supports FIXED, INCR and WRAP bursts, byte strobes, programmable address-ready latency, and OKAY/SLVERR/DECERR responses.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 64, data width; power of two, 32..256; STRB width = DATA_WIDTH/8
- ID_WIDTH, 4, transaction ID width
- MEM_DEPTH, 256, memory depth in DATA_WIDTH words
- BASE_ADDR, 0, byte address of word 0
- READY_DELAY, 0, cycles of AxVALID high before AxREADY asserts (0..15)

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- ARESET  in  1  asynchronous, active-high reset
- S_AWID  in  ID_WIDTH  write ID
- S_AWADDR  in  ADDR_WIDTH  write start address
- S_AWLEN  in  8  beats minus 1
- S_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
- S_AWVALID  in  1  AW valid
- S_AWREADY  out  1  AW ready
- S_WDATA  in  DATA_WIDTH  write data
- S_WSTRB  in  DATA_WIDTH/8  byte enables
- S_WLAST  in  1  last write beat
- S_WVALID  in  1  W valid
- S_WREADY  out  1  W ready
- S_BID  out  ID_WIDTH  response ID
- S_BRESP  out  2  write response
- S_BVALID  out  1  B valid
- S_BREADY  in  1  B ready
- S_ARID, S_ARADDR, S_ARLEN, S_ARBURST, S_ARVALID  in  as AW counterparts  read address channel
- S_ARREADY  out  1  AR ready
- S_RID  out  ID_WIDTH  read ID
- S_RDATA  out  DATA_WIDTH  read data
- S_RRESP  out  2  per-beat read response
- S_RLAST  out  1  last read beat
- S_RVALID  out  1  R valid
- S_RREADY  in  1  R ready

## Operation
- Beats are always full width; no SIZE port. Word index = (addr − BASE_ADDR) >> log2(DATA_WIDTH/8); the low address bits are ignored.
- A beat is in range when addr ≥ BASE_ADDR and index < MEM_DEPTH.
- Address advance per beat:
  - FIXED: unchanged.
  - INCR: +DATA_WIDTH/8.
  - WRAP: increments within an aligned window of (LEN+1)×bytes.
  - WRAP with LEN not in {1,3,7,15}, or BURST=11: executed as INCR, and the burst is flagged SLVERR.
- Write FSM W_IDLE → W_DATA → W_RESP:
  - W_IDLE: ready counter increments while AWVALID=1 and clears when AWVALID=0. AWREADY=1 when counter ≥ READY_DELAY.
  - On the AW handshake: latch ID, addr, len, burst; clear flags; go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the in-range bytes selected by WSTRB; out-of-range beats are dropped and set the DECERR flag.
  - WLAST=1 before beat LEN, or WLAST=0 on beat LEN: set the SLVERR flag and end the burst at that beat.
  - After the final beat go to W_RESP.
- W_RESP:
  - BVALID=1; BID = latched ID.
  - BRESP priority: DECERR 11 > SLVERR 10 > OKAY 00.
  - Hold until BREADY, then go to W_IDLE.
- Read FSM R_IDLE → R_DATA:
  - AR handshake uses the same READY_DELAY rule as AW.
  - R_DATA: RVALID=1; RDATA = mem[index], or 0 when out of range.
  - RRESP per beat: DECERR if out of range, else SLVERR if the burst is flagged, else OKAY. RLAST=1 on beat LEN.
  - Each R handshake loads the next beat; the handshake with RLAST returns to R_IDLE.
- Read and write paths are independent and may run concurrently.
- Memory contents are not reset.

## Timing
- Reset: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0. BID, BRESP, RID, RDATA, RRESP = 0. Both FSMs return to IDLE, aborting any burst in flight without a response.
- With READY_DELAY=0, AWREADY and ARREADY are 1 from the first edge after ARESET falls. With READY_DELAY=D, AxREADY rises D edges after AxVALID is first sampled high.
- WREADY rises on the edge of the AW handshake, so W beats can start the next cycle; one beat per cycle at full throughput.
- BVALID asserts on the edge after the last W handshake.
- RVALID and the first RDATA beat are registered and appear on the edge after the AR handshake. Back-to-back beats follow with no bubble while RREADY=1.
- All outputs are stable while VALID=1 and READY=0.
- Same-word write and read in the same cycle: the read returns the pre-write data; the write commits at that edge.
- AxREADY is 0 outside the IDLE states, so there is one outstanding transaction per direction.

## Test plan
- INCR write AWADDR=0x10, LEN=3, data 0xA0..0xA3, WSTRB all ones → BRESP=00 one cycle after the last beat. Read of the same burst → RDATA 0xA0..0xA3, RLAST on beat 4, RRESP=00.
- WRAP read ARADDR=0x28, LEN=3, DATA_WIDTH=64 → beat addresses 0x28, 0x30, 0x38, 0x20.
- Write AWADDR=BASE_ADDR+MEM_DEPTH×8 → BRESP=11. Read of the same address → RDATA=0, RRESP=11.
- Write with WLAST on beat 2 of LEN=3 → burst ends after beat 2, BRESP=10. WSTRB=0x0F beat → only the low 4 bytes change.
- READY_DELAY=3 with RREADY toggling 1/0 → AWREADY rises on the 3rd edge of AWVALID. RDATA is held stable while RREADY=0.
- ARESET asserted mid read burst → RVALID=0 within the same cycle and ARREADY=0. After release, ARREADY=1 and a new burst completes normally.
